// File: rtl/register_file_pkg.sv
// Shared widths and types for the 8 x 16-bit datapath register file.
package register_file_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_reg16_ld.sv
// One DATA_W-bit register with synchronous active-high reset and load enable.
module reg16_ld
  import register_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: non-blocking so every register samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// 8 x 16-bit register file: one synchronous write port, two combinational read ports.
module register_file
  import register_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] W_Adr,
  input  logic              we,
  input  logic [ADDR_W-1:0] R_Adr,
  input  logic [ADDR_W-1:0] S_Adr,
  input  logic [DATA_W-1:0] W,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S
);

  logic [DEPTH-1:0] ld;
  reg_data_t        q [DEPTH];

  // NOTE: default every bit first so the decoder stays combinational, not a latch.
  always_comb begin
    ld = '0;
    if (we) ld[W_Adr] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    reg16_ld u_reg (
      .clk   (clk),
      .reset (reset),
      .ld    (ld[i]),
      .d     (W),
      .q     (q[i])
    );
  end

  // No write bypass: reads show stored contents, so new data appears after the edge.
  always_comb begin
    R = q[R_Adr];
    S = q[S_Adr];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus hand-written corner sequences.
module tb_register_file;
  import register_file_pkg::*;

  logic      clk = 1'b0;
  logic      reset, we;
  reg_addr_t W_Adr, R_Adr, S_Adr;
  reg_data_t W, R, S;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string     name;
    reg_data_t exp_r;
    reg_data_t exp_s;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string     name;
    logic      rst;
    logic      we;
    reg_addr_t w_adr;
    reg_data_t w;
    reg_addr_t r_adr;
    reg_addr_t s_adr;
    reg_data_t exp_r;
    reg_data_t exp_s;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .W_Adr (W_Adr),
    .we    (we),
    .R_Adr (R_Adr),
    .S_Adr (S_Adr),
    .W     (W),
    .R     (R),
    .S     (S)
  );

  task automatic check(input string nm, input reg_data_t act, input reg_data_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_rs(input string nm, input reg_data_t er, input reg_data_t es);
    sb_t e;
    e.name = nm; e.exp_r = er; e.exp_s = es;
    sb_q.push_back(e);
  endtask

  task automatic compare_rs();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    check({e.name, ".R"}, R, e.exp_r);
    check({e.name, ".S"}, S, e.exp_s);
  endtask

  // Drive a vector at the falling edge, clock it in, then compare just after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; we = v.we; W_Adr = v.w_adr; W = v.w;
    R_Adr = v.r_adr; S_Adr = v.s_adr;
    expect_rs(v.name, v.exp_r, v.exp_s);
    @(posedge clk);
    #1;
    compare_rs();
  endtask

  // Combinational read with no clock edge in between.
  task automatic read_now(input string nm, input reg_addr_t ra, input reg_addr_t sa,
                          input reg_data_t er, input reg_data_t es);
    R_Adr = ra; S_Adr = sa;
    expect_rs(nm, er, es);
    #1;
    compare_rs();
  endtask

  function automatic vec_t mk(input string nm, input logic rst, input logic wen,
                              input reg_addr_t wa, input reg_data_t wd,
                              input reg_addr_t ra, input reg_addr_t sa,
                              input reg_data_t er, input reg_data_t es);
    vec_t v;
    v.name = nm; v.rst = rst; v.we = wen; v.w_adr = wa; v.w = wd;
    v.r_adr = ra; v.s_adr = sa; v.exp_r = er; v.exp_s = es;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reg_data_t pat;
    reset = 1'b0; we = 1'b0; W_Adr = '0; W = '0; R_Adr = '0; S_Adr = '0;

    // Vector table: reset, write ~i everywhere, read back on both ports, write-disable.
    vecs.push_back(mk("reset", 1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0000, 16'h0000));
    for (int i = 0; i < DEPTH; i++) begin
      pat = ~16'(i);
      vecs.push_back(mk($sformatf("write%0d", i), 1'b0, 1'b1, 3'(i), pat,
                        3'(i), 3'd0, pat, 16'hFFFF));
    end
    for (int i = 0; i < DEPTH; i++) begin
      vecs.push_back(mk($sformatf("read%0d", i), 1'b0, 1'b0, 3'd0, 16'h0000,
                        3'(i), 3'(7 - i), ~16'(i), ~16'(7 - i)));
    end
    vecs.push_back(mk("same_reg", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hFFFC, 16'hFFFC));
    vecs.push_back(mk("we_off", 1'b0, 1'b0, 3'd2, 16'h1234, 3'd2, 3'd2, 16'hFFFD, 16'hFFFD));

    // Hand sequence: after the reset vector, sweep reads with zero clock latency.
    apply(vecs[0]);
    for (int i = 0; i < DEPTH; i++)
      read_now($sformatf("rst_sweep%0d", i), 3'(i), 3'(7 - i), 16'h0000, 16'h0000);

    for (int k = 1; k < vecs.size(); k++) apply(vecs[k]);

    // Read-during-write: old value before the edge, new value just after it.
    @(negedge clk);
    reset = 1'b0; we = 1'b1; W_Adr = 3'd5; W = 16'hABCD;
    read_now("rdw_before", 3'd5, 3'd4, 16'hFFFA, 16'hFFFB);
    expect_rs("rdw_after", 16'hABCD, 16'hFFFB);
    @(posedge clk);
    #1;
    compare_rs();

    // Reset wins over a simultaneous write, and clears everything at that edge.
    @(negedge clk);
    reset = 1'b1; we = 1'b1; W_Adr = 3'd6; W = 16'h5555;
    read_now("rst_pri_before", 3'd6, 3'd5, 16'hFFF9, 16'hABCD);
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      read_now($sformatf("rst_pri%0d", i), 3'(i), 3'(7 - i), 16'h0000, 16'h0000);

    // A clock edge with we=0 after reset must keep everything at zero.
    apply(mk("idle_after_rst", 1'b0, 1'b0, 3'd6, 16'h5555, 3'd6, 3'd0, 16'h0000, 16'h0000));

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
